tx_frame_packer: RTL and testbench

- Upstream feeder for the half-duplex SNI transmitter; runs in the user clock domain.
- Accepts frame bytes from the switch core over a valid/ready stream and pads short frames to the Ethernet minimum.
- Appends the IEEE 802.3 CRC32 FCS and writes every byte into the TX FIFO. The final FCS byte carries the EOD flag.

---
 rtl/tx_frame_packer.sv | 176 +++++++++++++++++
 tb/tb_tx_frame_packer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_packer.sv
// tx_frame_packer: takes frame bytes from the switch core, pads short frames
// with zeros up to MIN_LEN, truncates long frames at MAX_LEN, appends the
// reflected CRC32 FCS and writes every byte into the TX FIFO. The last FCS
// byte carries the end-of-data flag.
module tx_frame_packer #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  fifo_din,
    output logic        fifo_EOD_in,
    output logic        fifo_wren,
    input  logic        fifo_afull,
    output logic [15:0] frame_cnt,
    output logic        err_oversize
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BODY = 3'd1,
        S_DROP = 3'd2,
        S_PAD  = 3'd3,
        S_FCS  = 3'd4
    } state_t;

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] ONE     = 11'd1;
    localparam logic [31:0] CRC_INI = 32'hFFFF_FFFF;

    state_t      r_state, w_state_nx;
    logic [31:0] r_crc, w_crc_nx;
    logic [10:0] r_byte_cnt, w_cnt_nx, w_cnt_inc;
    logic [1:0]  r_idx, w_idx_nx;
    logic [15:0] r_frame_cnt, w_fcnt_nx;
    logic        w_xfer;
    logic        w_wr, w_wr_eod, w_err;
    logic [7:0]  w_wr_data;
    logic [31:0] w_crc_inv;

    // One byte through the reflected CRC32, LSB of the byte shifted in first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Byte counter increment that never exceeds MAX_LEN.
    function automatic logic [10:0] sat_inc(input logic [10:0] c);
        return (c >= MAX_L) ? MAX_L : c + 11'd1;
    endfunction

    assign in_ready  = ((r_state == S_IDLE) || (r_state == S_BODY) || (r_state == S_DROP))
                       && !fifo_afull;
    assign w_xfer    = in_valid & in_ready;
    assign w_cnt_inc = sat_inc(r_byte_cnt);
    assign w_crc_inv = ~r_crc;

    // Next-state, datapath updates and the write decision for this cycle.
    always_comb begin
        w_state_nx = r_state;
        w_crc_nx   = r_crc;
        w_cnt_nx   = r_byte_cnt;
        w_idx_nx   = r_idx;
        w_fcnt_nx  = r_frame_cnt;
        w_wr       = 1'b0;
        w_wr_data  = 8'h00;
        w_wr_eod   = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_wr      = 1'b1;
                    w_wr_data = in_data;
                    w_crc_nx  = crc_byte(r_crc, in_data);
                    w_cnt_nx  = ONE;
                    if (in_last)
                        w_state_nx = (ONE >= MIN_L) ? S_FCS : S_PAD;
                    else if (ONE >= MAX_L)
                        w_state_nx = S_DROP;
                    else
                        w_state_nx = S_BODY;
                end
            end
            S_BODY: begin
                if (w_xfer) begin
                    w_wr      = 1'b1;
                    w_wr_data = in_data;
                    w_crc_nx  = crc_byte(r_crc, in_data);
                    w_cnt_nx  = w_cnt_inc;
                    if (in_last)
                        w_state_nx = (w_cnt_inc < MIN_L) ? S_PAD : S_FCS;
                    else if (w_cnt_inc == MAX_L)
                        w_state_nx = S_DROP;
                end
            end
            S_DROP: begin
                if (w_xfer && in_last) begin
                    w_err      = 1'b1;
                    w_state_nx = S_FCS;
                end
            end
            S_PAD: begin
                if (!fifo_afull) begin
                    w_wr     = 1'b1;
                    w_crc_nx = crc_byte(r_crc, 8'h00);
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc >= MIN_L)
                        w_state_nx = S_FCS;
                end
            end
            S_FCS: begin
                if (!fifo_afull) begin
                    w_wr     = 1'b1;
                    w_idx_nx = r_idx + 2'd1;
                    case (r_idx)
                        2'd0:    w_wr_data = w_crc_inv[7:0];
                        2'd1:    w_wr_data = w_crc_inv[15:8];
                        2'd2:    w_wr_data = w_crc_inv[23:16];
                        default: w_wr_data = w_crc_inv[31:24];
                    endcase
                    if (r_idx == 2'd3) begin
                        w_wr_eod   = 1'b1;
                        w_fcnt_nx  = r_frame_cnt + 16'd1;
                        w_crc_nx   = CRC_INI;
                        w_cnt_nx   = 11'd0;
                        w_idx_nx   = 2'd0;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_crc_nx   = CRC_INI;
                w_cnt_nx   = 11'd0;
                w_idx_nx   = 2'd0;
            end
        endcase
    end

    // State, CRC, counters and the registered FIFO write port.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_crc        <= CRC_INI;
            r_byte_cnt   <= 11'd0;
            r_idx        <= 2'd0;
            r_frame_cnt  <= 16'd0;
            fifo_din     <= 8'h00;
            fifo_EOD_in  <= 1'b0;
            fifo_wren    <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_crc        <= w_crc_nx;
            r_byte_cnt   <= w_cnt_nx;
            r_idx        <= w_idx_nx;
            r_frame_cnt  <= w_fcnt_nx;
            fifo_din     <= w_wr_data;
            fifo_EOD_in  <= w_wr_eod;
            fifo_wren    <= w_wr;
            err_oversize <= w_err;
        end
    end

    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_tx_frame_packer.sv
// Bench for tx_frame_packer: one instance with padding disabled for the
// "123456789" check vector, one with default parameters for everything else.
module tb_tx_frame_packer;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        fifo_afull = 1'b0;
    logic        sel = 1'b0;
    logic        pad_watch = 1'b0;

    logic        a_valid, a_ready, a_eod, a_wren, a_err;
    logic [7:0]  a_din;
    logic [15:0] a_fcnt;
    logic        b_valid, b_ready, b_eod, b_wren, b_err;
    logic [7:0]  b_din;
    logic [15:0] b_fcnt;
    logic        w_ready, m_wren, m_eod, m_err;
    logic [7:0]  m_din;

    assign a_valid = in_valid & ~sel;
    assign b_valid = in_valid & sel;
    assign w_ready = sel ? b_ready : a_ready;
    assign m_wren  = sel ? b_wren : a_wren;
    assign m_eod   = sel ? b_eod : a_eod;
    assign m_din   = sel ? b_din : a_din;
    assign m_err   = sel ? b_err : a_err;

    always #5 clk = ~clk;

    tx_frame_packer #(.MIN_LEN(0), .MAX_LEN(1514)) dut_a (
        .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(a_valid),
        .in_last(in_last), .in_ready(a_ready), .fifo_din(a_din),
        .fifo_EOD_in(a_eod), .fifo_wren(a_wren), .fifo_afull(fifo_afull),
        .frame_cnt(a_fcnt), .err_oversize(a_err)
    );

    tx_frame_packer dut_b (
        .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(b_valid),
        .in_last(in_last), .in_ready(b_ready), .fifo_din(b_din),
        .fifo_EOD_in(b_eod), .fifo_wren(b_wren), .fifo_afull(fifo_afull),
        .frame_cnt(b_fcnt), .err_oversize(b_err)
    );

    // Write capture and protocol monitors on the selected instance.
    logic [7:0] cap_data[$];
    logic       cap_eod[$];
    int         cap_cyc[$];
    int         cyc_n = 0;
    logic       prev_afull = 1'b0;
    int         afull_viol = 0;
    int         rdy_viol = 0;
    int         pad_viol = 0;
    int         err_cnt = 0;

    always @(negedge clk) begin
        cyc_n      <= cyc_n + 1;
        prev_afull <= fifo_afull;
        if (m_wren) begin
            cap_data.push_back(m_din);
            cap_eod.push_back(m_eod);
            cap_cyc.push_back(cyc_n);
            if (prev_afull) afull_viol <= afull_viol + 1;
            if (pad_watch && !m_eod && w_ready) pad_viol <= pad_viol + 1;
        end
        if (fifo_afull && w_ready) rdy_viol <= rdy_viol + 1;
        if (m_err) err_cnt <= err_cnt + 1;
    end

    int nchecks = 0;
    int nerr = 0;
    int acc_cnt = 0;
    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one byte and hold it until the selected instance accepts it.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        t = 0;
        forever begin
            @(negedge clk);
            if (w_ready) break;
            t++;
            if (t > 2000) break;
        end
        if (t > 2000) begin
            nchecks++;
            nerr++;
            $display("FAIL send_timeout: byte %0h not accepted within 2000 cycles", d);
        end else begin
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n     = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        fifo_afull = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input string nm, input int base, input int n, input int budget);
        int t;
        t = 0;
        while ((cap_data.size() - base) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        chk({nm, "_wrcount"}, cap_data.size() - base, n);
    endtask

    // Expected FIFO stream for pl_q on the default instance: truncate, pad, FCS.
    task automatic build_exp();
        int n;
        logic [31:0] c;
        logic fb;
        exp_q.delete();
        n = (pl_q.size() > 1514) ? 1514 : pl_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(pl_q[i]);
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ exp_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    task automatic cmp_frame(input string nm, input int base);
        int mism, neod, n;
        mism = 0;
        neod = 0;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (base + i >= cap_data.size()) mism++;
            else begin
                if (cap_data[base + i] !== exp_q[i]) mism++;
                if (cap_eod[base + i]) neod++;
            end
        end
        chk({nm, "_byte_mismatches"}, mism, 0);
        chk({nm, "_eod_count"}, neod, 1);
        chk({nm, "_eod_last"}, (base + n - 1 < cap_data.size()) ? 32'(cap_eod[base + n - 1]) : 32'd0, 1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       last;
        logic [7:0] exp_b;
        logic       exp_eod;
    } vec_t;

    vec_t vt[13];

    initial begin
        int base, e0, a0, dcyc;
        string s;

        vt[0]  = '{8'h31, 1'b0, 8'h31, 1'b0};
        vt[1]  = '{8'h32, 1'b0, 8'h32, 1'b0};
        vt[2]  = '{8'h33, 1'b0, 8'h33, 1'b0};
        vt[3]  = '{8'h34, 1'b0, 8'h34, 1'b0};
        vt[4]  = '{8'h35, 1'b0, 8'h35, 1'b0};
        vt[5]  = '{8'h36, 1'b0, 8'h36, 1'b0};
        vt[6]  = '{8'h37, 1'b0, 8'h37, 1'b0};
        vt[7]  = '{8'h38, 1'b0, 8'h38, 1'b0};
        vt[8]  = '{8'h39, 1'b1, 8'h39, 1'b0};
        vt[9]  = '{8'h00, 1'b0, 8'h26, 1'b0};
        vt[10] = '{8'h00, 1'b0, 8'hF4 ^ 8'hF4 ^ 8'h39, 1'b0};
        vt[11] = '{8'h00, 1'b0, 8'hF4, 1'b0};
        vt[12] = '{8'h00, 1'b0, 8'hCB, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fifo_din", b_din, 0);
        chk("rst_fifo_eod", b_eod, 0);
        chk("rst_fifo_wren", b_wren, 0);
        chk("rst_frame_cnt", b_fcnt, 0);
        chk("rst_err", b_err, 0);
        chk("rst_a_wren", a_wren, 0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        fifo_afull = 1'b1;
        #1;
        chk("idle_ready_afull", b_ready, 0);
        fifo_afull = 1'b0;
        #1;
        chk("idle_ready", b_ready, 1);

        // Check vector "123456789" with padding disabled
        sel  = 1'b0;
        base = cap_data.size();
        for (int i = 0; i < 9; i++) send(vt[i].din, vt[i].last);
        wait_writes("t1", base, 13, 100);
        for (int i = 0; i < 13; i++) begin
            s.itoa(i);
            chk({"t1_byte", s}, (base + i < cap_data.size()) ? 32'(cap_data[base + i]) : 32'hDEAD, 32'(vt[i].exp_b));
            chk({"t1_eod", s}, (base + i < cap_eod.size()) ? 32'(cap_eod[base + i]) : 32'hDEAD, 32'(vt[i].exp_eod));
        end
        chk("t1_frame_cnt", a_fcnt, 1);

        // Single byte frame padded to 60
        do_reset();
        sel       = 1'b1;
        pad_watch = 1'b1;
        base = cap_data.size();
        pl_q.delete();
        pl_q.push_back(8'hAB);
        send(8'hAB, 1'b1);
        wait_writes("t2", base, 64, 200);
        pad_watch = 1'b0;
        build_exp();
        cmp_frame("t2", base);
        chk("t2_ready_in_pad", pad_viol, 0);
        chk("t2_frame_cnt", b_fcnt, 1);

        // 100-byte frame, random valid gaps, FIFO almost-full stalls
        do_reset();
        base = cap_data.size();
        e0   = err_cnt;
        pl_q.delete();
        for (int i = 0; i < 100; i++) pl_q.push_back(8'(i * 7 + 3));
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pl_q[i], i == 99);
                end
            end
            begin
                int trig[3];
                int k, cyc;
                trig[0] = 10;
                trig[1] = 60;
                trig[2] = 101;
                k = 0;
                cyc = 0;
                while (k < 3 && cyc < 3000) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (cap_data.size() - base >= trig[k]) begin
                        fifo_afull = 1'b1;
                        repeat (5) @(posedge clk);
                        #1;
                        fifo_afull = 1'b0;
                        k++;
                    end
                end
                chk("t3_afull_schedule", k, 3);
            end
        join
        wait_writes("t3", base, 104, 400);
        build_exp();
        cmp_frame("t3", base);
        chk("t3_write_while_afull", afull_viol, 0);
        chk("t3_ready_while_afull", rdy_viol, 0);
        chk("t3_no_err", err_cnt - e0, 0);

        // Oversize frame truncated at MAX_LEN
        do_reset();
        base = cap_data.size();
        e0   = err_cnt;
        a0   = acc_cnt;
        pl_q.delete();
        for (int i = 0; i < 1600; i++) pl_q.push_back(8'((i * 13) ^ (i >> 8)));
        for (int i = 0; i < 1600; i++) send(pl_q[i], i == 1599);
        wait_writes("t4", base, 1518, 400);
        build_exp();
        cmp_frame("t4", base);
        chk("t4_accepted", acc_cnt - a0, 1600);
        chk("t4_err_pulses", err_cnt - e0, 1);
        chk("t4_frame_cnt", b_fcnt, 1);

        // Back-to-back 60-byte frames with valid held high
        do_reset();
        base = cap_data.size();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 60; i++) send(8'(i) ^ ((f == 1) ? 8'h5A : 8'h00), i == 59);
        wait_writes("t5", base, 128, 200);
        pl_q.delete();
        for (int i = 0; i < 60; i++) pl_q.push_back(8'(i));
        build_exp();
        cmp_frame("t5_f1", base);
        pl_q.delete();
        for (int i = 0; i < 60; i++) pl_q.push_back(8'(i) ^ 8'h5A);
        build_exp();
        cmp_frame("t5_f2", base + 64);
        dcyc = (cap_cyc.size() > base + 64) ? cap_cyc[base + 64] - cap_cyc[base + 59] : -1;
        chk("t5_gap_cycles", dcyc, 5);
        chk("t5_frame_cnt", b_fcnt, 2);

        // Reset in the middle of a frame body
        base = cap_data.size();
        for (int i = 0; i < 30; i++) send(8'hC0 + 8'(i), 1'b0);
        #1;
        arst_n = 1'b0;
        #1;
        chk("t6_rst_out", {b_din, b_eod, b_wren, b_err, b_fcnt}, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("t6_rst_hold", {b_din, b_eod, b_wren, b_err, b_fcnt}, 0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        e0 = 0;
        for (int i = base; i < cap_eod.size(); i++) if (cap_eod[i]) e0++;
        chk("t6_aborted_no_eod", e0, 0);
        base = cap_data.size();
        pl_q.delete();
        for (int i = 0; i < 60; i++) pl_q.push_back(8'hF0 - 8'(i));
        for (int i = 0; i < 60; i++) send(pl_q[i], i == 59);
        wait_writes("t6", base, 64, 200);
        build_exp();
        cmp_frame("t6", base);
        chk("t6_frame_cnt", b_fcnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
